// File: rtl/mcash_ch_read_req_issue.sv
`default_nettype none
// ============================================================================
// Module      : mcash_ch_read_req_issue
// Description : Per-channel read-request issue stage. Stamps each request
//               with a per-bank ROB number and bounds outstanding reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mcash_ch_read_req_issue #(
    parameter int CHANNEL_ID      = 0,
    parameter int ADDR_W          = 32,
    parameter int BANK_LSB        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ch_read_req_valid_i,
    output logic              ch_read_req_ready_o,
    input  logic [ADDR_W-1:0] ch_read_req_addr_i,
    output logic              xbar_req_valid_o,
    input  logic              xbar_req_allowIn_i,
    output logic [ADDR_W-1:0] xbar_req_addr_o,
    output logic [1:0]        xbar_req_bank_id_o,
    output logic [1:0]        xbar_req_ch_id_o,
    output logic [2:0]        xbar_req_rob_num_o,
    output logic              mcash_ch_read_req_kickoff_o,
    output logic [1:0]        mcash_ch_read_req_bank_id_o,
    input  logic              ch_rtn_data_valid_i,
    input  logic              ch_rtn_data_ready_i,
    output logic [3:0]        outstanding_o,
    output logic              credit_err_o
);

    localparam logic [1:0] c_ch_id = 2'(CHANNEL_ID);
    localparam logic [3:0] c_max   = 4'(MAX_OUTSTANDING);

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [1:0]        out_bank_q,  out_bank_d;
    logic [2:0]        out_rob_q,   out_rob_d;
    logic [3:0][2:0]   rob_cnt_q,   rob_cnt_d;
    logic [3:0]        outstanding_q, outstanding_d;
    logic              credit_err_q,  credit_err_d;

    logic              w_ready;
    logic              w_accept;
    logic              w_ret;
    logic              w_handshake;
    logic [1:0]        w_bank;

    // Ready uses only the registered count so returns never reach ready combinationally.
    assign w_ready     = (~out_valid_q | xbar_req_allowIn_i) & (outstanding_q < c_max);
    assign w_accept    = ch_read_req_valid_i & w_ready;
    assign w_ret       = ch_rtn_data_valid_i & ch_rtn_data_ready_i;
    assign w_handshake = out_valid_q & xbar_req_allowIn_i;
    assign w_bank      = ch_read_req_addr_i[BANK_LSB+1:BANK_LSB];

    always_comb begin
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_bank_d    = out_bank_q;
        out_rob_d     = out_rob_q;
        rob_cnt_d     = rob_cnt_q;
        outstanding_d = outstanding_q;
        credit_err_d  = credit_err_q;

        if (w_accept) begin
            out_valid_d       = 1'b1;
            out_addr_d        = ch_read_req_addr_i;
            out_bank_d        = w_bank;
            out_rob_d         = rob_cnt_q[w_bank];
            rob_cnt_d[w_bank] = rob_cnt_q[w_bank] + 3'd1;
        end else if (w_handshake) begin
            out_valid_d = 1'b0;
        end

        case ({w_accept, w_ret})
            2'b10: outstanding_d = outstanding_q + 4'd1;
            2'b01: begin
                if (outstanding_q == 4'd0) begin
                    credit_err_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - 4'd1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_bank_q    <= 2'd0;
            out_rob_q     <= 3'd0;
            rob_cnt_q     <= '0;
            outstanding_q <= 4'd0;
            credit_err_q  <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_bank_q    <= out_bank_d;
            out_rob_q     <= out_rob_d;
            rob_cnt_q     <= rob_cnt_d;
            outstanding_q <= outstanding_d;
            credit_err_q  <= credit_err_d;
        end
    end

    assign ch_read_req_ready_o         = w_ready;
    assign xbar_req_valid_o            = out_valid_q;
    assign xbar_req_addr_o             = out_addr_q;
    assign xbar_req_bank_id_o          = out_bank_q;
    assign xbar_req_ch_id_o            = c_ch_id;
    assign xbar_req_rob_num_o          = out_rob_q;
    assign mcash_ch_read_req_kickoff_o = w_handshake;
    assign mcash_ch_read_req_bank_id_o = out_bank_q;
    assign outstanding_o               = outstanding_q;
    assign credit_err_o                = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcash_ch_read_req_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcash_ch_read_req_issue
// Description : Directed self-checking bench for mcash_ch_read_req_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcash_ch_read_req_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ch_read_req_valid_i;
    logic        ch_read_req_ready_o;
    logic [31:0] ch_read_req_addr_i;
    logic        xbar_req_valid_o;
    logic        xbar_req_allowIn_i;
    logic [31:0] xbar_req_addr_o;
    logic [1:0]  xbar_req_bank_id_o;
    logic [1:0]  xbar_req_ch_id_o;
    logic [2:0]  xbar_req_rob_num_o;
    logic        mcash_ch_read_req_kickoff_o;
    logic [1:0]  mcash_ch_read_req_bank_id_o;
    logic        ch_rtn_data_valid_i;
    logic        ch_rtn_data_ready_i;
    logic [3:0]  outstanding_o;
    logic        credit_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mcash_ch_read_req_issue #(
        .CHANNEL_ID(0), .ADDR_W(32), .BANK_LSB(4), .MAX_OUTSTANDING(8)
    ) dut (
        .clk_i                       (clk_i),
        .rst_i                       (rst_i),
        .ch_read_req_valid_i         (ch_read_req_valid_i),
        .ch_read_req_ready_o         (ch_read_req_ready_o),
        .ch_read_req_addr_i          (ch_read_req_addr_i),
        .xbar_req_valid_o            (xbar_req_valid_o),
        .xbar_req_allowIn_i          (xbar_req_allowIn_i),
        .xbar_req_addr_o             (xbar_req_addr_o),
        .xbar_req_bank_id_o          (xbar_req_bank_id_o),
        .xbar_req_ch_id_o            (xbar_req_ch_id_o),
        .xbar_req_rob_num_o          (xbar_req_rob_num_o),
        .mcash_ch_read_req_kickoff_o (mcash_ch_read_req_kickoff_o),
        .mcash_ch_read_req_bank_id_o (mcash_ch_read_req_bank_id_o),
        .ch_rtn_data_valid_i         (ch_rtn_data_valid_i),
        .ch_rtn_data_ready_i         (ch_rtn_data_ready_i),
        .outstanding_o               (outstanding_o),
        .credit_err_o                (credit_err_o)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ret_credits(input int n);
        ch_rtn_data_valid_i = 1'b1;
        ch_rtn_data_ready_i = 1'b1;
        repeat (n) step();
        ch_rtn_data_valid_i = 1'b0;
        ch_rtn_data_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        ch_read_req_valid_i = 1'b0;
        xbar_req_allowIn_i  = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        checks++;
        if (xbar_req_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", xbar_req_valid_o);
        end
        checks++;
        if (mcash_ch_read_req_kickoff_o !== 1'b0) begin
            failures++; $display("FAIL reset_kickoff got=%b exp=0", mcash_ch_read_req_kickoff_o);
        end
        checks++;
        if (outstanding_o !== 4'd0 || credit_err_o !== 1'b0) begin
            failures++; $display("FAIL reset_credit got=%0d/%b exp=0/0", outstanding_o, credit_err_o);
        end
        checks++;
        if (ch_read_req_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", ch_read_req_ready_o);
        end
    endtask

    task automatic test_single();
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_addr_i  = 32'h20;
        ch_read_req_valid_i = 1'b1;
        step();
        ch_read_req_valid_i = 1'b0;
        checks++;
        if (xbar_req_valid_o !== 1'b1 || xbar_req_bank_id_o !== 2'd2 || xbar_req_rob_num_o !== 3'd0 ||
            xbar_req_ch_id_o !== 2'd0 || xbar_req_addr_o !== 32'h20) begin
            failures++;
            $display("FAIL single_req got v=%b bank=%0d rob=%0d ch=%0d addr=%h exp v=1 bank=2 rob=0 ch=0 addr=20",
                     xbar_req_valid_o, xbar_req_bank_id_o, xbar_req_rob_num_o, xbar_req_ch_id_o, xbar_req_addr_o);
        end
        checks++;
        if (mcash_ch_read_req_kickoff_o !== 1'b1 || mcash_ch_read_req_bank_id_o !== 2'd2) begin
            failures++;
            $display("FAIL single_kickoff got=%b bank=%0d exp=1 bank=2",
                     mcash_ch_read_req_kickoff_o, mcash_ch_read_req_bank_id_o);
        end
        checks++;
        if (outstanding_o !== 4'd1) begin
            failures++; $display("FAIL single_outstanding got=%0d exp=1", outstanding_o);
        end
        ret_credits(1);
        checks++;
        if (xbar_req_valid_o !== 1'b0 || outstanding_o !== 4'd0) begin
            failures++; $display("FAIL single_drain got v=%b out=%0d exp v=0 out=0", xbar_req_valid_o, outstanding_o);
        end
    endtask

    task automatic test_back_to_back();
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_addr_i  = 32'h10;
        ch_read_req_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (xbar_req_valid_o !== 1'b1 || xbar_req_rob_num_o !== 3'(i) || xbar_req_bank_id_o !== 2'd1 ||
                mcash_ch_read_req_kickoff_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_issue[%0d] got v=%b rob=%0d bank=%0d ko=%b exp v=1 rob=%0d bank=1 ko=1",
                         i, xbar_req_valid_o, xbar_req_rob_num_o, xbar_req_bank_id_o, mcash_ch_read_req_kickoff_o, i);
            end
        end
        checks++;
        if (ch_read_req_ready_o !== 1'b0 || outstanding_o !== 4'd8) begin
            failures++; $display("FAIL b2b_full got rdy=%b out=%0d exp rdy=0 out=8", ch_read_req_ready_o, outstanding_o);
        end
        step();
        checks++;
        if (xbar_req_valid_o !== 1'b0 || ch_read_req_ready_o !== 1'b0) begin
            failures++; $display("FAIL b2b_stall got v=%b rdy=%b exp v=0 rdy=0", xbar_req_valid_o, ch_read_req_ready_o);
        end
        ch_read_req_valid_i = 1'b0;
        ret_credits(1);
        checks++;
        if (ch_read_req_ready_o !== 1'b1 || outstanding_o !== 4'd7) begin
            failures++; $display("FAIL b2b_refill got rdy=%b out=%0d exp rdy=1 out=7", ch_read_req_ready_o, outstanding_o);
        end
        ch_read_req_valid_i = 1'b1;
        step();
        ch_read_req_valid_i = 1'b0;
        checks++;
        if (xbar_req_valid_o !== 1'b1 || xbar_req_rob_num_o !== 3'd0) begin
            failures++; $display("FAIL b2b_wrap got v=%b rob=%0d exp v=1 rob=0", xbar_req_valid_o, xbar_req_rob_num_o);
        end
        ret_credits(8);
    endtask

    task automatic test_bank_sequence();
        logic [1:0] banks [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
        logic [2:0] robs  [5] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd2};
        test_reset();
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ch_read_req_addr_i = {26'd0, banks[i], 4'h5};
            step();
            checks++;
            if (xbar_req_rob_num_o !== robs[i] || mcash_ch_read_req_kickoff_o !== 1'b1 ||
                mcash_ch_read_req_bank_id_o !== banks[i]) begin
                failures++;
                $display("FAIL bank_seq[%0d] got rob=%0d ko=%b bank=%0d exp rob=%0d ko=1 bank=%0d",
                         i, xbar_req_rob_num_o, mcash_ch_read_req_kickoff_o, mcash_ch_read_req_bank_id_o,
                         robs[i], banks[i]);
            end
        end
        ch_read_req_valid_i = 1'b0;
        ret_credits(5);
    endtask

    task automatic test_backpressure();
        int kicks = 0;
        test_reset();
        xbar_req_allowIn_i  = 1'b0;
        ch_read_req_addr_i  = 32'h3C;
        ch_read_req_valid_i = 1'b1;
        step();
        ch_read_req_addr_i = 32'h100;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xbar_req_valid_o !== 1'b1 || xbar_req_addr_o !== 32'h3C || xbar_req_bank_id_o !== 2'd3 ||
                xbar_req_rob_num_o !== 3'd0 || ch_read_req_ready_o !== 1'b0 || mcash_ch_read_req_kickoff_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b addr=%h bank=%0d rob=%0d rdy=%b ko=%b exp v=1 addr=3c bank=3 rob=0 rdy=0 ko=0",
                         i, xbar_req_valid_o, xbar_req_addr_o, xbar_req_bank_id_o, xbar_req_rob_num_o,
                         ch_read_req_ready_o, mcash_ch_read_req_kickoff_o);
            end
            step();
        end
        ch_read_req_valid_i = 1'b0;
        xbar_req_allowIn_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mcash_ch_read_req_kickoff_o === 1'b1) kicks++;
            step();
        end
        checks++;
        if (kicks != 1) begin
            failures++; $display("FAIL bp_release_kickoffs got=%0d exp=1", kicks);
        end
        ret_credits(1);
    endtask

    task automatic test_credits();
        test_reset();
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_addr_i  = 32'h0;
        ch_read_req_valid_i = 1'b1;
        repeat (5) step();
        checks++;
        if (outstanding_o !== 4'd5) begin
            failures++; $display("FAIL credit_five got=%0d exp=5", outstanding_o);
        end
        ch_rtn_data_valid_i = 1'b1;
        ch_rtn_data_ready_i = 1'b1;
        step();
        ch_read_req_valid_i = 1'b0;
        ch_rtn_data_valid_i = 1'b0;
        ch_rtn_data_ready_i = 1'b0;
        checks++;
        if (outstanding_o !== 4'd5) begin
            failures++; $display("FAIL credit_acc_ret got=%0d exp=5", outstanding_o);
        end
        ret_credits(5);
        checks++;
        if (outstanding_o !== 4'd0 || credit_err_o !== 1'b0) begin
            failures++; $display("FAIL credit_drain got=%0d/%b exp=0/0", outstanding_o, credit_err_o);
        end
        ret_credits(1);
        checks++;
        if (outstanding_o !== 4'd0 || credit_err_o !== 1'b1) begin
            failures++; $display("FAIL credit_underflow got=%0d/%b exp=0/1", outstanding_o, credit_err_o);
        end
        step();
        checks++;
        if (credit_err_o !== 1'b1) begin
            failures++; $display("FAIL credit_err_sticky got=%b exp=1", credit_err_o);
        end
        test_reset();
    endtask

    task automatic test_reset_held();
        test_reset();
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_addr_i  = 32'h20;
        ch_read_req_valid_i = 1'b1;
        repeat (3) step();
        xbar_req_allowIn_i  = 1'b0;
        ch_read_req_valid_i = 1'b0;
        step();
        checks++;
        if (xbar_req_valid_o !== 1'b1 || xbar_req_rob_num_o !== 3'd2 || outstanding_o !== 4'd3) begin
            failures++;
            $display("FAIL held_setup got v=%b rob=%0d out=%0d exp v=1 rob=2 out=3",
                     xbar_req_valid_o, xbar_req_rob_num_o, outstanding_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if (xbar_req_valid_o !== 1'b0 || outstanding_o !== 4'd0 || mcash_ch_read_req_kickoff_o !== 1'b0) begin
            failures++;
            $display("FAIL held_reset got v=%b out=%0d ko=%b exp v=0 out=0 ko=0",
                     xbar_req_valid_o, outstanding_o, mcash_ch_read_req_kickoff_o);
        end
        xbar_req_allowIn_i  = 1'b1;
        ch_read_req_valid_i = 1'b1;
        step();
        ch_read_req_valid_i = 1'b0;
        checks++;
        if (xbar_req_valid_o !== 1'b1 || xbar_req_rob_num_o !== 3'd0 || xbar_req_bank_id_o !== 2'd2) begin
            failures++;
            $display("FAIL held_restart got v=%b rob=%0d bank=%0d exp v=1 rob=0 bank=2",
                     xbar_req_valid_o, xbar_req_rob_num_o, xbar_req_bank_id_o);
        end
    endtask

    initial begin
        rst_i               = 1'b1;
        ch_read_req_valid_i = 1'b0;
        ch_read_req_addr_i  = 32'h0;
        xbar_req_allowIn_i  = 1'b1;
        ch_rtn_data_valid_i = 1'b0;
        ch_rtn_data_ready_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bank_sequence();
        test_backpressure();
        test_credits();
        test_reset_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
